// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the parametrised APB register file.
// Imported by the top level and by the per-register slice.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    // Widest register the byte-merge helper supports; callers extend and truncate.
    localparam int MAX_DATA_WIDTH = 512;
    localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

    typedef logic [MAX_DATA_WIDTH-1:0] word_t;
    typedef logic [MAX_BYTES-1:0]      strb_t;

    function automatic int byte_count(input int data_width);
        return data_width / 8;
    endfunction

    // Counter must hold values 0..wait_states inclusive.
    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

    function automatic word_t byte_merge(input word_t old_val, input word_t new_val,
                                         input strb_t strb);
        word_t res;
        res = old_val;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_rf_reg.sv
// One register slice: reset value, hardware d/en load, and byte-strobed APB
// commit where strobed bytes take bus data and unstrobed bytes follow hardware.
module apb_rf_reg
    import apb_regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   hw_d,
    input  logic                    hw_en,
    input  logic                    apb_we,
    input  logic [DATA_WIDTH-1:0]   apb_wdata,
    input  logic [DATA_WIDTH/8-1:0] apb_strb,
    output logic [DATA_WIDTH-1:0]   q
);

    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] next_q;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        base   = hw_en ? hw_d : q;
        merged = DATA_WIDTH'(byte_merge(word_t'(base), word_t'(apb_wdata), strb_t'(apb_strb)));
        next_q = apb_we ? merged : base;
    end

    // NOTE: this is a control register, not a RAM array, so it takes an async reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/apb_regfile_param.sv
// Parametrised APB3 register file: transfer FSM with programmable wait states,
// address decode, error response, read mux and per-register write pulses.
module apb_regfile_param
    import apb_regfile_pkg::*;
#(
    parameter int                             NUM_REGS    = 4,
    parameter int                             DATA_WIDTH  = 32,
    parameter int                             ADDR_WIDTH  = 2,
    parameter int                             WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           apb_PCLK,
    input  logic                           apb_PRESET,
    input  logic [ADDR_WIDTH-1:0]          apb_PADDR,
    input  logic                           apb_PSEL,
    input  logic                           apb_PENABLE,
    input  logic                           apb_PWRITE,
    input  logic [DATA_WIDTH-1:0]          apb_PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        apb_PSTRB,
    input  logic [2:0]                     apb_PPROT,
    output logic [DATA_WIDTH-1:0]          apb_PRDATA,
    output logic                           apb_PREADY,
    output logic                           apb_PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_d,
    input  logic [NUM_REGS-1:0]            reg_en,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int CNT_W     = cnt_width(WAIT_STATES);
    localparam int NUM_BYTES = byte_count(DATA_WIDTH);

    apb_state_e            state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [NUM_REGS-1:0]   addr_sel;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  err;
    logic                  commit;
    logic                  unused_pprot;

    assign unused_pprot = ^apb_PPROT;

    // An address with no matching register decodes to an empty select vector.
    always_comb begin
        addr_sel = '0;
        rd_word  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr_sel[i] = (int'(apb_PADDR) == i);
            if (addr_sel[i]) rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign err = ~|addr_sel | (apb_PWRITE & |(addr_sel & RO_MASK));

    // Deselecting the slave mid-access withdraws the response as well as the commit.
    assign apb_PREADY   = (state == ACCESS) && (wait_cnt == CNT_W'(WAIT_STATES)) && apb_PSEL;
    assign apb_PSLVERR  = apb_PREADY & err;
    assign commit       = apb_PREADY & apb_PENABLE & apb_PWRITE & ~err;
    assign apb_PRDATA   = (apb_PREADY & ~apb_PWRITE & ~err) ? rd_word : '0;
    assign reg_wr_pulse = commit ? addr_sel : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge apb_PCLK or posedge apb_PRESET) begin
        if (apb_PRESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (apb_PSEL && !apb_PENABLE) state <= SETUP;
                end
                SETUP: begin
                    if (!apb_PSEL) begin
                        state <= IDLE;
                    end else if (apb_PENABLE) begin
                        state    <= ACCESS;
                        wait_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (!apb_PSEL) begin
                        state <= IDLE;
                    end else if (apb_PREADY) begin
                        state <= (apb_PSEL && !apb_PENABLE) ? SETUP : IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        apb_rf_reg #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_reg (
            .clk       (apb_PCLK),
            .rst       (apb_PRESET),
            .hw_d      (reg_d[i*DATA_WIDTH +: DATA_WIDTH]),
            .hw_en     (reg_en[i]),
            .apb_we    (commit & addr_sel[i]),
            .apb_wdata (apb_PWDATA),
            .apb_strb  (apb_PSTRB[NUM_BYTES-1:0]),
            .q         (reg_q[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
